seg7_scan_ctrl: RTL
===================

# seg7_scan_ctrl

Parametrised multiplexed seven-segment display controller with an internal digit register file. Host logic writes 4-bit hex values, decimal-point and blank flags into per-digit slots. The block time-multiplexes all digits onto one shared segment bus at a programmable refresh rate. It adds leading-zero suppression, an inter-digit ghosting gap and a frame strobe, and sits between the board switch/host logic and the seven-segment anodes/cathodes.

## Interface
- NUM_DIGITS, 8, number of digits scanned (2..16).
- DIV, 100000, clk cycles per digit slot (>=2).
- SEG_ACTIVE_LOW, 1, 1 = segments/dp drive 0 to light.
- AN_ACTIVE_LOW, 1, 1 = anodes drive 0 to enable.
- AW, $clog2(NUM_DIGITS), derived address width (localparam).

- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  write strobe, one slot per asserted cycle.
- wr_addr  in  AW  digit slot; 0 = rightmost (least significant).
- wr_data  in  4  hex value.
- wr_dp  in  1  decimal point for the slot.
- wr_blank  in  1  force slot dark.
- lz_blank  in  1  enable leading-zero suppression (level, sampled each cycle).
- segments  out  7  {a,b,c,d,e,f,g}, registered.
- dp  out  1  decimal point, registered.
- anode  out  NUM_DIGITS  digit enables, registered, one-hot when active.
- frame_tick  out  1  one-cycle pulse when scan wraps to digit 0.

## Operation
- Register file: NUM_DIGITS entries of {blank, dp, value[3:0]}. On wr_en, the addressed entry is loaded at the clock edge. wr_addr >= NUM_DIGITS is ignored with no side effect.
- Prescaler: counts 0..DIV-1 and wraps. tick = (count == DIV-1).
- Scan index: 0..NUM_DIGITS-1. On tick it increments, wrapping to 0 after NUM_DIGITS-1. frame_tick is asserted in the cycle the index wraps (registered, same edge as the index update).
- Leading-zero suppression, when lz_blank=1:
  - Digit i is suppressed if value==0 and every digit j>i has value==0 or blank=1.
  - Digit 0 is never suppressed.
  - dp of a suppressed digit is also dark.
- A digit is dark if blank=1 or it is suppressed. For a dark digit, segments and dp are off, but its anode is still driven. This keeps the duty cycle constant.
- Decode, active-high lit polarity (bit order a..g): 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Output polarity: the decoded pattern is inverted when SEG_ACTIVE_LOW=1; anode is inverted when AN_ACTIVE_LOW=1.
- "Off" for segments, dp and anode means the inactive level of the chosen polarity.

## Timing
- Reset values:
  - Register file all zero (value 0, dp 0, blank 0); prescaler 0; index 0; frame_tick 0.
  - segments, dp and anode all off.
- Cycle t with tick=1: index updates, and anode, segments and dp are loaded off. This is a one-cycle ghosting gap.
- Cycle t+1: anode, segments and dp are loaded from the new index and the current register file.
- The new digit is visible from t+2 until the next tick gap. Each digit is lit for DIV-1 of every DIV cycles.
- Write latency: a write at edge t is visible on the outputs at edge t+1 if its slot is currently being scanned (registered output follows the register file one cycle later).
- Simultaneous write and scan of the same slot: the display shows the old value for one cycle, then the new one. There is no tearing within a cycle.
- lz_blank change takes effect on the next output register load.
- reset mid-scan: all state returns to reset values at the next edge. The first post-reset tick occurs DIV cycles after reset deasserts.
- Full frame period = NUM_DIGITS*DIV cycles. frame_tick spacing is exactly that.

## Test plan
- Reset:
  - Stimulus: NUM_DIGITS=4, DIV=4, default polarities; hold reset 3 cycles.
  - Required: anode=1111, segments=1111111, dp=1, frame_tick=0. After release, anode=1110 and segments=0000001 (digit 0 shows 0).
- Scan order:
  - Stimulus: write slots 0..3 = 1,2,3,4.
  - Required: anode follows 1110→1111(gap)→1101→…→0111. segments in each slot are 1001111, 0010010, 0000110, 1001100. frame_tick pulses every 16 cycles.
- Leading-zero suppression:
  - Stimulus: slots {3,2,1,0} = {0,0,5,0}, lz_blank=1.
  - Required: slots 3 and 2 dark (segments=1111111), slot 1 = 0100100, slot 0 = 0000001. With lz_blank=0, slot 3 = 0000001.
- Blank and dp:
  - Stimulus: write slot 2 with value 8, dp=1, blank=0, then rewrite it with blank=1.
  - Required: first segments=0000000 and dp=0; after the rewrite, slot 2 is dark while its anode is still asserted.
- Out-of-range write:
  - Stimulus: NUM_DIGITS=6, write addr 7 value F.
  - Required: no slot changes.
- Reset mid-scan and polarity:
  - Stimulus: assert reset at index 2; separately, use SEG_ACTIVE_LOW=0 and AN_ACTIVE_LOW=0.
  - Required: after reset, index returns to 0 with all outputs off. With the alternate polarities, digit 0 value 0 gives segments=1111110, and anode=0001 when lit, 0000 in the gap.

Source files
------------

// File: rtl/seg7_scan_ctrl_if.sv
// rtl/seg7_scan_ctrl_if.sv - digit register file write port
interface seg7_scan_ctrl_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_data;
  logic          wr_dp;
  logic          wr_blank;

  modport master (output wr_en, wr_addr, wr_data, wr_dp, wr_blank);
  modport slave  (input  wr_en, wr_addr, wr_data, wr_dp, wr_blank);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed seven-segment scanner with digit register file
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS     = 8,
  parameter int DIV            = 100000,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  seg7_scan_ctrl_if.slave       wr,
  input  logic                  lz_blank,
  output logic [6:0]            segments,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] anode,
  output logic                  frame_tick
);
  localparam int AW = $clog2(NUM_DIGITS);
  localparam int CW = $clog2(DIV);
  localparam logic [6:0]            SEG_OFF = {7{SEG_ACTIVE_LOW}};
  localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF  = {NUM_DIGITS{AN_ACTIVE_LOW}};

  logic [NUM_DIGITS-1:0][3:0] rf_val;
  logic [NUM_DIGITS-1:0]      rf_dp;
  logic [NUM_DIGITS-1:0]      rf_blank;
  logic [NUM_DIGITS-1:0]      suppress;
  logic [CW-1:0]              pcnt;
  logic [AW-1:0]              idx;
  logic                       tick;
  logic                       addr_ok;
  logic                       above_clear;
  logic                       dark;

  // Only non-power-of-two digit counts can see an address past the last slot.
  generate
    if (NUM_DIGITS == (1 << AW)) begin : g_full
      assign addr_ok = 1'b1;
    end else begin : g_part
      assign addr_ok = (wr.wr_addr < AW'(NUM_DIGITS));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      rf_val   <= '0;
      rf_dp    <= '0;
      rf_blank <= '0;
    end else if (wr.wr_en && addr_ok) begin
      rf_val[wr.wr_addr]   <= wr.wr_data;
      rf_dp[wr.wr_addr]    <= wr.wr_dp;
      rf_blank[wr.wr_addr] <= wr.wr_blank;
    end
  end

  assign tick = (pcnt == CW'(DIV - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= '0;
      idx        <= '0;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      if (tick) begin
        pcnt <= '0;
        if (idx == AW'(NUM_DIGITS - 1)) begin
          idx        <= '0;
          frame_tick <= 1'b1;
        end else begin
          idx <= idx + AW'(1);
        end
      end else begin
        pcnt <= pcnt + CW'(1);
      end
    end
  end

  // Walk down from the most significant digit; blank slots count as zero above.
  always_comb begin
    suppress    = '0;
    above_clear = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      suppress[i] = lz_blank && above_clear && (rf_val[i] == 4'h0);
      above_clear = above_clear && (rf_blank[i] || (rf_val[i] == 4'h0));
    end
  end

  function automatic logic [6:0] decode(input logic [3:0] v);
    case (v)
      4'h0:    decode = 7'b1111110;
      4'h1:    decode = 7'b0110000;
      4'h2:    decode = 7'b1101101;
      4'h3:    decode = 7'b1111001;
      4'h4:    decode = 7'b0110011;
      4'h5:    decode = 7'b1011011;
      4'h6:    decode = 7'b1011111;
      4'h7:    decode = 7'b1110000;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1111011;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b0011111;
      4'hC:    decode = 7'b1001110;
      4'hD:    decode = 7'b0111101;
      4'hE:    decode = 7'b1001111;
      default: decode = 7'b1000111;
    endcase
  endfunction

  assign dark = rf_blank[idx] || suppress[idx];

  // XOR with the off level applies the polarity; tick cycles form the ghosting gap.
  always_ff @(posedge clk) begin
    if (reset || tick) begin
      segments <= SEG_OFF;
      dp       <= DP_OFF;
      anode    <= AN_OFF;
    end else begin
      anode    <= AN_OFF ^ (NUM_DIGITS'(1) << idx);
      segments <= dark ? SEG_OFF : (SEG_OFF ^ decode(rf_val[idx]));
      dp       <= (dark || !rf_dp[idx]) ? DP_OFF : ~DP_OFF;
    end
  end
endmodule
